// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples sck/cs/mosi on clk, shifts MSB-first frames up to max_length bits.
// Optional SPI_TARGET_OVERFLOW_EN builds a 9-bit edge counter to flag frames longer than max_length.
module spi_target #(
   parameter int max_length = 88
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sck,
   input  logic                  cs,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [max_length-1:0] tx_data,
   output logic [max_length-1:0] data_received,
   output logic [7:0]            bits_received,
   output logic                  frame_valid,
   output logic                  busy,
   output logic                  overflow
);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [2:0]            r_sck_sync;
   logic [2:0]            r_cs_sync;
   logic [1:0]            r_mosi_sync;
   logic [2:0]            r_warm;
   logic [max_length-1:0] r_tx;
   logic [max_length-1:0] r_rx;
   logic [7:0]            r_cnt;
   logic                  w_sck_rise;
   logic                  w_sck_fall;
   logic                  w_cs_rise;
   logic                  w_cs_fall;
   logic                  w_mosi_s;
   logic                  w_start;
   logic                  w_ovf;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sck_sync  <= 3'b000;
         r_cs_sync   <= 3'b111;
         r_mosi_sync <= 2'b00;
         r_warm      <= 3'b000;
      end else begin
         r_sck_sync  <= {r_sck_sync[1:0], sck};
         r_cs_sync   <= {r_cs_sync[1:0], cs};
         r_mosi_sync <= {r_mosi_sync[0], mosi};
         r_warm      <= {r_warm[1:0], 1'b1};
      end
   end

   assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
   assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
   assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
   assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
   assign w_mosi_s   = r_mosi_sync[1];

   // r_warm holds off frame starts until the synchronizer carries the real pin level,
   // so a cs already low across reset cannot fake a falling edge.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_cs_fall && r_warm[2]) w_next_state = ACTIVE;
         ACTIVE:  if (w_cs_rise) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   assign w_start = (r_state == IDLE) && (w_next_state == ACTIVE);
   assign busy    = (r_state != IDLE);
   assign miso    = r_tx[max_length-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx          <= '0;
         r_rx          <= '0;
         r_cnt         <= '0;
         data_received <= '0;
         bits_received <= '0;
         frame_valid   <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_tx  <= tx_data;
                  r_rx  <= '0;
                  r_cnt <= '0;
               end
            end
            ACTIVE: begin
               // cs rising takes priority; any sck edge in the same cycle is dropped
               if (w_cs_rise) begin
                  r_tx <= '0;
               end else if (w_sck_rise) begin
                  r_rx <= {r_rx[max_length-2:0], w_mosi_s};
                  if (r_cnt < 8'(max_length)) r_cnt <= r_cnt + 8'd1;
               end else if (w_sck_fall) begin
                  r_tx <= {r_tx[max_length-2:0], 1'b0};
               end
            end
            DONE: begin
               data_received <= r_rx;
               bits_received <= r_cnt;
               overflow      <= w_ovf;
               frame_valid   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SPI_TARGET_OVERFLOW_EN
   logic [8:0] r_ecnt;

   always_ff @(posedge clk) begin
      if (reset)
         r_ecnt <= '0;
      else if (w_start)
         r_ecnt <= '0;
      else if (r_state == ACTIVE && !w_cs_rise && w_sck_rise && r_ecnt <= 9'(max_length))
         r_ecnt <= r_ecnt + 9'd1;
   end

   assign w_ovf = (r_ecnt > 9'(max_length));
`else
   assign w_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Randomized + directed bench for spi_target with a frame-level reference model and a per-cycle monitor.
module tb_spi_target;
   localparam int ML = 88;

   logic          clk = 0, reset = 1, sck = 0, cs = 1, mosi = 0;
   logic          miso;
   logic [ML-1:0] tx_data = '0;
   logic [ML-1:0] data_received;
   logic [7:0]    bits_received;
   logic          frame_valid, busy, overflow;

   int n_chk = 0, n_fail = 0, cyc = 0, fv_count = 0;
   bit mon_en = 0;
   logic [ML-1:0] q_data[$];
   int            q_bits[$];
   logic          q_ovf[$];
   int            q_dl[$];
   logic [ML-1:0] last_data = '0;
   int            last_bits = 0;

   spi_target #(.max_length(ML)) dut (
      .clk(clk), .reset(reset), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
      .tx_data(tx_data), .data_received(data_received), .bits_received(bits_received),
      .frame_valid(frame_valid), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Output monitor: frame strobes must match the model queue, with fixed latency after cs rise.
   always @(negedge clk) begin
      if (reset) begin
         last_data = '0;
         last_bits = 0;
      end else if (mon_en) begin
         if (!busy) chk("miso_idle", miso, 0);
         if (frame_valid) begin
            fv_count++;
            if (q_data.size() == 0) chk("unexpected_frame_valid", 1, 0);
            else begin
               chk("data_received", data_received, q_data[0]);
               chk("bits_received", bits_received, q_bits[0]);
               chk("overflow", overflow, q_ovf[0]);
               chk("fv_latency", cyc - q_dl[0], 4);
               last_data = q_data.pop_front();
               last_bits = q_bits.pop_front();
               void'(q_ovf.pop_front());
               void'(q_dl.pop_front());
            end
         end else begin
            chk("data_held", data_received, last_data);
            chk("bits_held", bits_received, last_bits);
            if (q_data.size() != 0 && cyc > q_dl[0] + 6) begin
               chk("fv_timeout", 0, 1);
               void'(q_data.pop_front()); void'(q_bits.pop_front());
               void'(q_ovf.pop_front());  void'(q_dl.pop_front());
            end
         end
      end
   end

   // Initiator: n bits of pat (bit n-1 first), 8-clk sck phases, miso checked before each rise.
   task automatic send_frame(input int n, input logic [127:0] pat, input logic [ML-1:0] tx,
                             input int lead, input int gap, output logic [7:0] first8);
      logic [ML-1:0] e;
      logic          b;
      e = '0;
      first8 = '0;
      tx_data = tx;
      cs = 0;
      tick(lead);
      tx_data = ~tx;
      for (int i = 0; i < n; i++) begin
         b = pat[n-1-i];
         mosi = b;
         e = {e[ML-2:0], b};
         tick(8);
         chk("miso_bit", miso, (i < ML) ? tx[ML-1-i] : 1'b0);
         if (i < 8) first8[7-i] = miso;
         sck = 1;
         tick(8);
         sck = 0;
      end
      tick(8);
      cs = 1;
      q_data.push_back(e);
      q_bits.push_back(n > ML ? ML : n);
`ifdef SPI_TARGET_OVERFLOW_EN
      q_ovf.push_back(n > ML);
`else
      q_ovf.push_back(1'b0);
`endif
      q_dl.push_back(cyc);
      tick(gap);
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]   m8;
      logic [127:0] pat;
      logic [95:0]  rtx;
      int           fv0, n;

      tick(3);
      reset = 0;
      tick(1);
      chk("rst_miso", miso, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_valid", frame_valid, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_data", data_received, 0);
      chk("rst_bits", bits_received, 0);
      mon_en = 1;
      tick(4);

      send_frame(8, 128'hA5, 88'h3C << 80, 8, 10, m8);
      chk("t1_miso_seq", m8, 8'b00111100);
      chk("t1_data", data_received, 88'hA5);
      chk("t1_bits", bits_received, 8);

      send_frame(88, 128'h03_1234_0123456789ABCDEF, {ML{1'b1}}, 8, 10, m8);
      chk("t2_data", data_received, 88'h03_1234_0123456789ABCDEF);
      chk("t2_bits", bits_received, 88);
      chk("t2_ovf", overflow, 0);

      pat = 128'h3_FEDCBA9876543210_0F1E2D;
      send_frame(90, pat, 88'hA5A5_5A5A_0000_FFFF_1234_56, 8, 10, m8);
      chk("t3_data", data_received, 88'hFEDCBA9876543210_0F1E2D);
      chk("t3_bits", bits_received, 88);
`ifdef SPI_TARGET_OVERFLOW_EN
      chk("t3_ovf", overflow, 1);
`else
      chk("t3_ovf", overflow, 0);
`endif

      send_frame(0, 128'h0, 88'hFF << 80, 20, 10, m8);
      chk("t4_bits", bits_received, 0);
      chk("t4_data", data_received, 0);
      fv0 = fv_count;
      for (int i = 0; i < 4; i++) begin
         sck = 1; tick(4); sck = 0; tick(4);
      end
      tick(10);
      chk("t4_no_frame_cs_high", fv_count, fv0);
      chk("t4_busy", busy, 0);

      // Abort mid-frame with reset, then a clean frame
      cs = 0; tick(8);
      for (int i = 0; i < 5; i++) begin
         mosi = i[0]; tick(8); sck = 1; tick(8); sck = 0;
      end
      reset = 1; tick(2); reset = 0; tick(6);
      cs = 1; tick(12);
      chk("t5_abort_no_fv", fv_count, fv0);
      chk("t5_data_reset", data_received, 0);
      send_frame(16, 128'hBEEF, '0, 8, 10, m8);
      chk("t5_data", data_received, 88'hBEEF);

      fv0 = fv_count;
      send_frame(8, 128'h11, 88'h5A << 80, 8, 3, m8);
      send_frame(8, 128'h22, 88'hC3 << 80, 8, 12, m8);
      chk("t6_two_pulses", fv_count - fv0, 2);
      chk("t6_data", data_received, 88'h22);

      for (int k = 0; k < 10; k++) begin
         pat = {$urandom, $urandom, $urandom, $urandom};
         rtx = {$urandom, $urandom, $urandom};
         n = $urandom_range(0, 95);
         send_frame(n, pat, rtx[ML-1:0], $urandom_range(4, 12), $urandom_range(3, 10), m8);
      end

      tick(20);
      chk("queue_drained", q_data.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
